// File: rtl/hls_run_collector.sv
// hls_run_collector
//
// Sequencer and result buffer for an ap_ctrl_hs HLS core. A command
// launches cmd_count back-to-back core runs, one at a time. Each ap_return
// is captured on ap_done into a small FIFO. The FIFO drains on a
// valid/ready stream, and the final result of each command is tagged
// with out_last. A run is only launched when a FIFO slot is guaranteed,
// so no result is ever dropped.
//
// Optional feature: define RUN_TIMEOUT_EN to enable a per-state watchdog.
// The watchdog sets err_timeout and aborts the command. Without the
// macro, err_timeout is constant 0.
//
// Ports
//   ap_clk, ap_rst        clock; asynchronous active-high reset
//   cmd_start, cmd_count  one-cycle command pulse and number of runs
//   busy, cmd_done        command in progress / one-cycle completion pulse
//   err_timeout           sticky watchdog flag
//   core_start            to core ap_start
//   core_ready/done/idle  from core ap_ready / ap_done / ap_idle
//   core_return           from core ap_return, valid while core_done=1
//   out_valid/ready/data/last  result stream (FIFO head)
//   fsm_state             sequencer state for observation
//                         (0 idle, 1 launch, 2 wait, 3 fin)
//
// Handshake: a beat transfers on a rising ap_clk edge where out_valid and
// out_ready are both 1. out_data/out_last are held while out_valid=1 and
// out_ready=0. On the core side, a run is accepted on the edge where
// core_start and core_ready are both 1.
module hls_run_collector #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              cmd_start,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              busy,
    output logic              cmd_done,
    output logic              err_timeout,
    output logic              core_start,
    input  logic              core_ready,
    input  logic              core_done,
    input  logic              core_idle,
    input  logic [DATA_W-1:0] core_return,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        fsm_state
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;

    logic [DATA_W:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic handoff;      // core accepted a run this cycle
    logic run_done;     // the in-flight run finished this cycle
    logic push;
    logic pop;
    logic space;
    logic last_run;
    logic in_run;
    logic timeout_hit;

    assign handoff  = (state == S_LAUNCH) && core_start && core_ready;
    // A zero-latency core may raise done together with ready; that counts
    // as ready followed by done in the same cycle.
    assign run_done = ((state == S_WAIT) && core_done) || (handoff && core_done);
    assign push     = run_done;
    assign pop      = (count != '0) && out_ready;
    assign space    = count < (PTR_W + 1)'(DEPTH);
    assign last_run = (remaining == CNT_W'(1));
    assign in_run   = (state == S_LAUNCH) || (state == S_WAIT);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            busy       <= 1'b0;
            cmd_done   <= 1'b0;
            core_start <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            if (timeout_hit) begin
                // Abort: buffered results stay in the FIFO.
                state      <= S_IDLE;
                busy       <= 1'b0;
                cmd_done   <= 1'b1;
                core_start <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd_start) begin
                            remaining <= cmd_count;
                            busy      <= 1'b1;
                            if (cmd_count == '0) begin
                                state <= S_FIN;
                            end else begin
                                state      <= S_LAUNCH;
                                // Only one run is ever in flight and nothing
                                // pushes in IDLE, so current space is safe.
                                core_start <= space && core_idle;
                            end
                        end
                    end
                    S_LAUNCH: begin
                        if (core_start) begin
                            if (core_ready) begin
                                core_start <= 1'b0;
                                if (core_done) begin
                                    remaining <= remaining - 1'b1;
                                    if (last_run) begin
                                        state    <= S_FIN;
                                        cmd_done <= 1'b1;
                                    end
                                end else begin
                                    state <= S_WAIT;
                                end
                            end
                        end else if (space && core_idle) begin
                            core_start <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (core_done) begin
                            remaining <= remaining - 1'b1;
                            if (last_run) begin
                                state    <= S_FIN;
                                cmd_done <= 1'b1;
                            end else begin
                                state <= S_LAUNCH;
                            end
                        end
                    end
                    S_FIN: begin
                        // Entered from WAIT with the pulse already raised;
                        // a zero-count command arrives here with it low and
                        // raises it one cycle later.
                        if (cmd_done) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cmd_done <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign fsm_state = state;

    // --------------------------------------------------------------- FIFO
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {last_run, core_return};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr][DATA_W-1:0];
    assign out_last  = mem[rd_ptr][DATA_W];

    // ----------------------------------------------------------- watchdog
`ifdef RUN_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

    logic [TIMER_W-1:0] timer;
    logic               err_q;

    // Restarts on every LAUNCH/WAIT entry: IDLE holds it at zero, and a
    // handoff or finished run is always a state entry.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            timer <= '0;
        end else if (!in_run || handoff || run_done) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Progress in the same cycle wins over the watchdog.
    assign timeout_hit = in_run && !handoff && !run_done &&
                         (timer == TIMER_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if ((state == S_IDLE) && cmd_start) begin
            err_q <= 1'b0;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0 & in_run;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hls_run_collector.sv
// Directed bench for hls_run_collector with a behavioural ap_ctrl_hs core.
module tb_hls_run_collector;

    localparam int DW = 32;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          cmd_start = 1'b0;
    logic [15:0]   cmd_count = '0;
    logic          busy, cmd_done, err_timeout, core_start;
    logic          core_ready, core_done, core_idle;
    logic [DW-1:0] core_return;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    fsm_state;

    hls_run_collector #(
        .DATA_W(32), .DEPTH(4), .CNT_W(16), .TIMEOUT_CYC(16)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .cmd_start(cmd_start), .cmd_count(cmd_count),
        .busy(busy), .cmd_done(cmd_done), .err_timeout(err_timeout),
        .core_start(core_start), .core_ready(core_ready),
        .core_done(core_done), .core_idle(core_idle),
        .core_return(core_return),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .fsm_state(fsm_state)
    );

    // ------------------------------------------------- clock and reset
    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit reached cyc=%0d", cyc);
        $fatal(1);
    end

    // ------------------------------------------------- core model controls
    int            core_lat = 1;
    int            ready_dly = 0;
    bit            hang = 1'b0;
    int            force_req = 0;
    int            clear_req = 0;
    logic [DW-1:0] ret_base = '0;
    int            ret_ref = 0;

    int  model_runs = 0;
    int  m_hold = 0, m_lat = 0, m_id = 0, m_force_seen = 0, m_clear_seen = 0;
    bit  m_run = 1'b0;

    initial begin : core_model
        core_ready = 1'b0; core_done = 1'b0; core_idle = 1'b1; core_return = '0;
        forever begin
            @(posedge ap_clk); #1;
            core_ready = 1'b0;
            core_done  = 1'b0;
            if (ap_rst || clear_req != m_clear_seen) begin
                m_clear_seen = clear_req;
                m_run = 1'b0; m_hold = 0; core_idle = 1'b1;
            end else if (force_req != m_force_seen) begin
                m_force_seen = force_req;
                core_done = 1'b1; core_return = 32'hDEAD_BEEF;
            end else if (m_run) begin
                if (!hang && m_lat == 0) begin
                    core_done = 1'b1;
                    core_return = ret_base + 32'(m_id - ret_ref);
                    m_run = 1'b0; core_idle = 1'b1;
                end else if (m_lat > 0) begin
                    m_lat--;
                end
            end else if (core_start) begin
                if (m_hold == ready_dly) begin
                    core_ready = 1'b1; m_hold = 0;
                    m_id = model_runs; model_runs++;
                    if (core_lat == 0) begin
                        core_done = 1'b1;
                        core_return = ret_base + 32'(m_id - ret_ref);
                    end else begin
                        m_run = 1'b1; m_lat = core_lat - 1; core_idle = 1'b0;
                    end
                end else begin
                    m_hold++;
                end
            end
        end
    end

    // ------------------------------------------------- monitor / scoreboard
    logic [DW:0] exp_q[$];
    logic [DW:0] got_q[$];

    int launches = 0, start_hi = 0, cmd_done_cnt = 0;
    int cmd_done_cyc = -1, done_cyc = -1, valid_rise_cyc = -1, busy_fall_cyc = -1;
    int wait_entry_cyc = -1, ready_cyc = -1, start_fall_cyc = -1;
    bit prev_valid = 1'b0, prev_busy = 1'b0, prev_start = 1'b0;
    logic [1:0] prev_state = 2'd0;

    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (core_start) start_hi++;
            if (core_start && core_ready) begin launches++; ready_cyc = cyc; end
            if (prev_start && !core_start) start_fall_cyc = cyc;
            if (cmd_done) begin cmd_done_cnt++; cmd_done_cyc = cyc; end
            if (core_done) done_cyc = cyc;
            if (out_valid && !prev_valid) valid_rise_cyc = cyc;
            if (!busy && prev_busy) busy_fall_cyc = cyc;
            if (fsm_state == 2'd2 && prev_state != 2'd2) wait_entry_cyc = cyc;
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
        end
        prev_valid = out_valid;
        prev_busy  = busy;
        prev_start = core_start;
        prev_state = fsm_state;
    end

    int total = 0;
    int bad = 0;

    // ------------------------------------------------- driver tasks
    task automatic send_cmd(input int n);
        @(posedge ap_clk); #1;
        cmd_start = 1'b1;
        cmd_count = 16'(n);
        @(posedge ap_clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ap_clk); #1;
            if (cmd_done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ------------------------------------------------- tests
    task automatic test_reset;
        ap_rst = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        total++;
        if ({busy, cmd_done, err_timeout, core_start, out_valid, out_last} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {busy, cmd_done, err_timeout, core_start, out_valid, out_last});
        end
        total++;
        if (out_data !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", out_data);
        end
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        total++;
        if (fsm_state !== 2'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle state=%0d busy=%b exp state=0 busy=0", fsm_state, busy);
        end
    endtask

    task automatic test_single;
        int b_done, b_launch, b_got;
        bit ok;
        out_ready = 1'b1; core_lat = 5; ready_dly = 0;
        ret_base = 32'h7; ret_ref = model_runs;
        b_done = cmd_done_cnt; b_launch = launches; b_got = got_q.size();
        send_cmd(1);
        total++;
        if (busy !== 1'b1 || core_start !== 1'b1) begin
            bad++; $display("FAIL single_t1 busy=%b core_start=%b exp 1 1", busy, core_start);
        end
        wait_done(b_done, 60, ok);
        repeat (4) @(posedge ap_clk);
        #1;
        total++;
        if (!ok) begin bad++; $display("FAIL single_wait no cmd_done within budget"); end
        total++;
        if (got_q.size() != b_got + 1 || got_q[b_got] !== {1'b1, 32'h7}) begin
            bad++; $display("FAIL single_beat beats=%0d first=%h exp 1 beat 100000007",
                            got_q.size() - b_got, got_q[b_got]);
        end
        total++;
        if (cmd_done_cnt - b_done != 1 || launches - b_launch != 1) begin
            bad++; $display("FAIL single_counts done=%0d launches=%0d exp 1 1",
                            cmd_done_cnt - b_done, launches - b_launch);
        end
        total++;
        if (valid_rise_cyc != done_cyc + 1 || cmd_done_cyc != done_cyc + 1 ||
            busy_fall_cyc != done_cyc + 2) begin
            bad++; $display("FAIL single_timing D=%0d valid=%0d cmd_done=%0d busy_fall=%0d exp D+1 D+1 D+2",
                            done_cyc, valid_rise_cyc, cmd_done_cyc, busy_fall_cyc);
        end
    endtask

    task automatic test_zero_count;
        int b_launch;
        b_launch = launches;
        send_cmd(0);
        total++;
        if (busy !== 1'b1 || core_start !== 1'b0 || cmd_done !== 1'b0) begin
            bad++; $display("FAIL zero_t1 busy=%b core_start=%b cmd_done=%b exp 1 0 0",
                            busy, core_start, cmd_done);
        end
        @(posedge ap_clk); #1;
        total++;
        if (cmd_done !== 1'b1) begin bad++; $display("FAIL zero_t2 cmd_done=%b exp 1", cmd_done); end
        @(posedge ap_clk); #1;
        total++;
        if (cmd_done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_t3 cmd_done=%b busy=%b exp 0 0", cmd_done, busy);
        end
        total++;
        if (launches != b_launch) begin
            bad++; $display("FAIL zero_launch launches=%0d exp 0", launches - b_launch);
        end
    endtask

    task automatic test_busy_ignore;
        int b_done, b_launch, b_got;
        bit ok;
        logic [DW:0] got;
        out_ready = 1'b1; core_lat = 3; ready_dly = 0;
        ret_base = 32'h200; ret_ref = model_runs;
        b_done = cmd_done_cnt; b_launch = launches; b_got = got_q.size();
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back({i == 2, 32'h200 + 32'(i)});
        send_cmd(3);
        repeat (2) @(posedge ap_clk);
        send_cmd(5);
        wait_done(b_done, 80, ok);
        repeat (30) @(posedge ap_clk);
        #1;
        total++;
        if (!ok) begin bad++; $display("FAIL busy_wait no cmd_done within budget"); end
        total++;
        if (cmd_done_cnt - b_done != 1 || launches - b_launch != 3 || busy !== 1'b0) begin
            bad++; $display("FAIL busy_counts done=%0d launches=%0d busy=%b exp 1 3 0",
                            cmd_done_cnt - b_done, launches - b_launch, busy);
        end
        total++;
        if (got_q.size() != b_got + 3) begin
            bad++; $display("FAIL busy_nbeats got=%0d exp=3", got_q.size() - b_got);
        end
        for (int i = 0; i < 3; i++) begin
            got = (b_got + i < got_q.size()) ? got_q[b_got + i] : 'x;
            total++;
            if (got !== exp_q[i]) begin
                bad++; $display("FAIL busy_beat%0d got=%h exp=%h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int b_done, b_launch, b_got;
        bit ok;
        logic [DW:0] got;
        out_ready = 1'b0; core_lat = 2; ready_dly = 0;
        ret_base = 32'h100; ret_ref = model_runs;
        b_done = cmd_done_cnt; b_launch = launches; b_got = got_q.size();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({i == 5, 32'h100 + 32'(i)});
        send_cmd(6);
        repeat (40) @(posedge ap_clk);
        #1;
        total++;
        if (launches - b_launch != 4 || core_start !== 1'b0 || fsm_state !== 2'd1) begin
            bad++; $display("FAIL bp_stall launches=%0d core_start=%b state=%0d exp 4 0 1",
                            launches - b_launch, core_start, fsm_state);
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h100 || out_last !== 1'b0) begin
            bad++; $display("FAIL bp_head valid=%b data=%h last=%b exp 1 00000100 0",
                            out_valid, out_data, out_last);
        end
        out_ready = 1'b1;
        wait_done(b_done, 100, ok);
        repeat (4) @(posedge ap_clk);
        #1;
        total++;
        if (!ok) begin bad++; $display("FAIL bp_wait no cmd_done within budget"); end
        total++;
        if (got_q.size() != b_got + 6 || launches - b_launch != 6) begin
            bad++; $display("FAIL bp_nbeats beats=%0d launches=%0d exp 6 6",
                            got_q.size() - b_got, launches - b_launch);
        end
        for (int i = 0; i < 6; i++) begin
            got = (b_got + i < got_q.size()) ? got_q[b_got + i] : 'x;
            total++;
            if (got !== exp_q[i]) begin
                bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_handshake_hold;
        int b_done, b_hi, b_got;
        bit ok;
        out_ready = 1'b1; core_lat = 2; ready_dly = 10;
        ret_base = 32'h55; ret_ref = model_runs;
        b_done = cmd_done_cnt; b_hi = start_hi; b_got = got_q.size();
        send_cmd(1);
        wait_done(b_done, 60, ok);
        repeat (3) @(posedge ap_clk);
        #1;
        ready_dly = 0;
        total++;
        if (!ok) begin bad++; $display("FAIL hold_wait no cmd_done within budget"); end
        total++;
        if (start_hi - b_hi != 11) begin
            bad++; $display("FAIL hold_cycles core_start high=%0d exp=11", start_hi - b_hi);
        end
        total++;
        if (start_fall_cyc != ready_cyc + 1) begin
            bad++; $display("FAIL hold_fall fall=%0d ready=%0d exp ready+1", start_fall_cyc, ready_cyc);
        end
        total++;
        if (got_q.size() != b_got + 1 || got_q[b_got] !== {1'b1, 32'h55}) begin
            bad++; $display("FAIL hold_beat beats=%0d first=%h exp 1 100000055",
                            got_q.size() - b_got, got_q[b_got]);
        end
    endtask

    task automatic test_zero_latency;
        int b_done, b_launch, b_got;
        bit ok;
        logic [DW:0] got;
        out_ready = 1'b1; core_lat = 0; ready_dly = 0;
        ret_base = 32'h300; ret_ref = model_runs;
        b_done = cmd_done_cnt; b_launch = launches; b_got = got_q.size();
        exp_q.delete();
        exp_q.push_back({1'b0, 32'h300});
        exp_q.push_back({1'b1, 32'h301});
        send_cmd(2);
        wait_done(b_done, 40, ok);
        repeat (3) @(posedge ap_clk);
        #1;
        total++;
        if (!ok || launches - b_launch != 2) begin
            bad++; $display("FAIL zlat_done ok=%b launches=%0d exp 1 2", ok, launches - b_launch);
        end
        for (int i = 0; i < 2; i++) begin
            got = (b_got + i < got_q.size()) ? got_q[b_got + i] : 'x;
            total++;
            if (got !== exp_q[i]) begin
                bad++; $display("FAIL zlat_beat%0d got=%h exp=%h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int b_launch, b_got;
        bit reached;
        out_ready = 1'b0; core_lat = 4; ready_dly = 0;
        ret_base = 32'h400; ret_ref = model_runs;
        b_launch = launches; b_got = got_q.size();
        send_cmd(4);
        reached = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge ap_clk); #1;
            if (launches - b_launch >= 3) begin reached = 1'b1; break; end
        end
        @(negedge ap_clk); #2;
        total++;
        if (!reached || fsm_state !== 2'd2 || out_valid !== 1'b1) begin
            bad++; $display("FAIL rmid_setup reached=%b state=%0d valid=%b exp 1 2 1",
                            reached, fsm_state, out_valid);
        end
        ap_rst = 1'b1;
        #1;
        total++;
        if ({busy, cmd_done, err_timeout, core_start, out_valid, out_last} !== 6'b0 ||
            out_data !== 32'h0 || fsm_state !== 2'd0) begin
            bad++; $display("FAIL rmid_async flags=%b data=%h state=%0d exp 000000 0 0",
                            {busy, cmd_done, err_timeout, core_start, out_valid, out_last},
                            out_data, fsm_state);
        end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        force_req++;
        out_ready = 1'b1;
        repeat (5) @(posedge ap_clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || got_q.size() != b_got) begin
            bad++; $display("FAIL rmid_stray valid=%b busy=%b beats=%0d exp 0 0 0",
                            out_valid, busy, got_q.size() - b_got);
        end
    endtask

`ifdef RUN_TIMEOUT_EN
    task automatic test_timeout;
        int b_done, b_got;
        bit ok;
        out_ready = 1'b1; core_lat = 1; ready_dly = 0; hang = 1'b1;
        b_done = cmd_done_cnt;
        send_cmd(1);
        wait_done(b_done, 60, ok);
        total++;
        if (!ok || err_timeout !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL tmo_abort ok=%b err=%b busy=%b exp 1 1 0", ok, err_timeout, busy);
        end
        total++;
        if (cmd_done_cyc != wait_entry_cyc + 16) begin
            bad++; $display("FAIL tmo_timing wait_entry=%0d cmd_done=%0d exp entry+16",
                            wait_entry_cyc, cmd_done_cyc);
        end
        hang = 1'b0;
        clear_req++;
        repeat (3) @(posedge ap_clk);
        ret_base = 32'h600; ret_ref = model_runs;
        b_done = cmd_done_cnt; b_got = got_q.size();
        send_cmd(1);
        total++;
        if (err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear err=%b exp 0", err_timeout); end
        wait_done(b_done, 40, ok);
        repeat (3) @(posedge ap_clk);
        #1;
        total++;
        if (!ok || got_q.size() != b_got + 1 || got_q[b_got] !== {1'b1, 32'h600}) begin
            bad++; $display("FAIL tmo_rerun ok=%b beats=%0d first=%h exp 1 1 100000600",
                            ok, got_q.size() - b_got, got_q[b_got]);
        end
    endtask
`else
    task automatic test_no_timeout;
        int b_done, b_got;
        bit ok;
        out_ready = 1'b1; core_lat = 40; ready_dly = 0;
        ret_base = 32'h500; ret_ref = model_runs;
        b_done = cmd_done_cnt; b_got = got_q.size();
        send_cmd(1);
        wait_done(b_done, 100, ok);
        repeat (3) @(posedge ap_clk);
        #1;
        total++;
        if (!ok || err_timeout !== 1'b0) begin
            bad++; $display("FAIL notmo_done ok=%b err=%b exp 1 0", ok, err_timeout);
        end
        total++;
        if (got_q.size() != b_got + 1 || got_q[b_got] !== {1'b1, 32'h500}) begin
            bad++; $display("FAIL notmo_beat beats=%0d first=%h exp 1 100000500",
                            got_q.size() - b_got, got_q[b_got]);
        end
    endtask
`endif

    // ------------------------------------------------- sequence and report
    initial begin
        test_reset();
        test_single();
        test_zero_count();
        test_busy_ignore();
        test_backpressure();
        test_handshake_hold();
        test_zero_latency();
        test_reset_mid();
`ifdef RUN_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (2) @(posedge ap_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hls_run_collector.md
# hls_run_collector

Sequencer and result buffer that sits directly downstream of the HLS adder core (`top_add`) and drives its ap_ctrl_hs handshake. On a command it launches N back-to-back core runs. It captures each `ap_return` on the core's `ap_done` pulse into a small FIFO, and presents results on a valid/ready stream with a last marker. It never launches a run unless FIFO space is guaranteed, so no result is ever dropped.

## Interface
Parameters:
- `DATA_W`, 32, width of the core return and of `out_data`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, 16, width of the run-count command.
- `TIMEOUT_CYC`, 1024, watchdog limit in cycles; used only with `RUN_TIMEOUT_EN`.

Ports:
- `ap_clk` in 1: single clock, all logic rising-edge.
- `ap_rst` in 1: reset, asynchronous, active-high.
- `cmd_start` in 1: one-cycle command pulse.
- `cmd_count` in CNT_W: runs to perform; sampled with `cmd_start`.
- `busy` out 1: command in progress.
- `cmd_done` out 1: one-cycle pulse when a command finishes or aborts.
- `err_timeout` out 1: sticky watchdog flag; tied 0 without `RUN_TIMEOUT_EN`.
- `core_start` out 1: to core `ap_start`.
- `core_ready` in 1: from core `ap_ready`.
- `core_done` in 1: from core `ap_done`.
- `core_idle` in 1: from core `ap_idle`.
- `core_return` in DATA_W: from core `ap_return`; valid only while `core_done`=1.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out DATA_W: FIFO head data.
- `out_last` out 1: head is the final result of its command.

## Operation
- FSM states:
  - IDLE: `busy`=0. Entered from reset, on command completion, or on abort. `cmd_start` here latches `remaining`=`cmd_count`.
    - If `cmd_count`=0: go to FIN.
    - Otherwise: go to LAUNCH.
  - LAUNCH: wait until FIFO occupancy < DEPTH and `core_idle`=1, then assert `core_start`. Hold `core_start` high until a cycle with `core_ready`=1. Go to WAIT the cycle after `core_ready`.
  - WAIT: `core_start`=0. On `core_done`=1, push {`remaining`==1, `core_return`} into the FIFO and decrement `remaining`.
    - If `remaining` becomes 0: go to FIN.
    - Otherwise: go to LAUNCH.
  - If `core_done` and `core_ready` arrive in the same cycle in LAUNCH (zero-latency core), treat it as ready followed by done in that cycle: push and transition as in WAIT.
  - FIN: pulse `cmd_done` for one cycle, then go to IDLE.
- Only one run is ever in flight. LAUNCH gating on FIFO space therefore guarantees a slot at done time. The FIFO does not overflow.
- FIFO: DEPTH entries of DATA_W+1 bits, with a log2(DEPTH)+1-bit occupancy count. Read and write pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged.
  - Pop when empty: ignored.
  - `out_valid` = count≠0.
  - `out_data`/`out_last` come from the head entry and are stable while `out_valid`=1 and `out_ready`=0.
- `cmd_start` while `busy`=1 is ignored. A new command may start while earlier results are still in the FIFO.
- `core_done` outside WAIT/LAUNCH is ignored (no push).

## Timing
- Reset values: `busy`=0, `cmd_done`=0, `err_timeout`=0, `core_start`=0, `out_valid`=0, `out_last`=0, `out_data`=0. FIFO is emptied and the FSM enters IDLE.
- Reset is asserted asynchronously and released synchronously to `ap_clk`. Reset mid-command drops `core_start` immediately and discards all buffered results.
- `cmd_start` at cycle T: `busy`=1 at T+1. `core_start`=1 at T+1 if the FIFO has space and `core_idle`=1.
- `core_done` at cycle D: result is visible at `out_data` with `out_valid`=1 at D+1, if the FIFO was empty.
- Next launch: `core_start`=1 no earlier than D+1.
- Final result: `cmd_done` pulses at D+1 and `busy`=0 at D+2.
- `cmd_count`=0: `cmd_done` pulses at T+2; no `core_start`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `RUN_TIMEOUT_EN` defined:
  - A cycle counter runs in LAUNCH and WAIT and resets on each state entry.
  - When it reaches TIMEOUT_CYC: set `err_timeout`, drop `core_start`, pulse `cmd_done`, return to IDLE. Results already in the FIFO are kept.
  - `err_timeout` clears on the next accepted `cmd_start`.
- `RUN_TIMEOUT_EN` undefined: no counter; `err_timeout` is constant 0; the FSM waits indefinitely.

## Test plan
- Reset mid-run: assert `ap_rst` while in WAIT with 2 entries buffered → all outputs at reset values immediately; FIFO empty; a later `core_done` is ignored.
- Single run: `cmd_count`=1, core returns 0x0000_0007 after 5 cycles → one beat `out_data`=0x7, `out_last`=1; `cmd_done` pulses once.
- Backpressure: `cmd_count`=6, DEPTH=4, `out_ready`=0 → exactly 4 launches, then `core_start` stays 0. Raising `out_ready` releases runs 5–6; 6 beats in order, `out_last` only on beat 6.
- Zero count and busy-ignore:
  - `cmd_count`=0 → `cmd_done` at T+2, no `core_start`.
  - `cmd_start` during a busy 3-run command → still exactly 3 results.
- Handshake hold: core delays `core_ready` 10 cycles → `core_start` held high all 10 cycles, then deasserted the cycle after.
- `RUN_TIMEOUT_EN` with TIMEOUT_CYC=16 and core never asserting done → `err_timeout`=1 and `cmd_done` pulse 16 cycles after WAIT entry; the next `cmd_start` clears the flag.
